imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time controller that owns the instruction-memory write path after reset. It accepts a program image as a word stream over a valid/ready handshake and writes it sequentially into instruction memory. It holds the CPU in stall until the image is complete and its checksum verifies. It sits between the external load interface and the instruction memory's write port; the fetch port stays read-only.

## Interface
- IMEM_BITS, default `IMEM_BITS from defines.v: instruction-memory word-address width.
- BASE_ADDR, default 0: first word address written.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- load_valid  in  1  load_data holds a valid word.
- load_data  in  32  stream word: header, then payload, then checksum.
- load_ready  out  1  loader accepts the word this cycle.
- imem_we  out  1  write strobe to instruction memory.
- imem_addr  out  32  word address; upper bits above IMEM_BITS are zero.
- imem_wdata  out  32  write data.
- cpu_stall  out  1  holds the pipeline; high whenever state is not DONE.
- done  out  1  image loaded and verified.
- error  out  1  header out of range or checksum mismatch.

## Operation
- Handshake: a word is accepted when load_valid && load_ready on a rising edge. load_ready is high only in HEADER, LOAD and CHECK, and does not depend on load_valid.
- States: IDLE, HEADER, LOAD, CHECK, DONE, ERROR.
- IDLE: all outputs low except cpu_stall = 1. start moves to HEADER.
- HEADER: the accepted word is N, the payload word count.
  - N == 0 moves to CHECK.
  - N > 2^IMEM_BITS - BASE_ADDR moves to ERROR.
  - Otherwise: latch N, clear index i and checksum, move to LOAD.
- LOAD: each accepted word d is written to address BASE_ADDR + i.
  - csum ^= d, then i++.
  - After the N-th word, move to CHECK.
- CHECK: the accepted word is compared with csum. Equal moves to DONE; unequal moves to ERROR.
- DONE: done = 1, cpu_stall = 0. start moves to HEADER and reasserts cpu_stall the next cycle.
- ERROR: error = 1, cpu_stall = 1. start moves to HEADER. Words already written are not undone.
- start is ignored in HEADER, LOAD and CHECK.
- Width rules:
  - i and N are IMEM_BITS+1 bits wide, so N = 2^IMEM_BITS is representable.
  - Addresses never wrap, because the range check happens in HEADER.
  - csum is 32 bits, XOR only.

## Timing
- Write latency: a payload word accepted at edge t appears as imem_we = 1 with imem_addr and imem_wdata during cycle t+1. The outputs are registered, and the strobe lasts exactly one cycle per word.
- Throughput: one word per cycle when load_valid is held high. No bubbles occur between HEADER, LOAD and CHECK.
- The last payload write (cycle t+1) overlaps the first CHECK cycle. The checksum can therefore be accepted at edge t+1.
- done and error are registered and rise the cycle after the deciding CHECK or HEADER acceptance.
- reset asserted at any time:
  - state goes to IDLE immediately, and a write in flight is dropped (imem_we = 0);
  - outputs read imem_we = 0, load_ready = 0, done = 0, error = 0, cpu_stall = 1, and imem_addr and imem_wdata = 0.
- Reset values for the internal registers: i = 0, N = 0, csum = 0.

## Structure
- The state encoding (6 states, localparam, 3 bits) and the HEADER range-limit expression belong in defines.v beside IMEM_SIZE/IMEM_BITS. The fetch-side stall logic reuses them.
- The block is a single module with no sub-module. The registered write-port stage is small enough to stay inline.
- The instruction memory gains a clocked we/waddr/wdata port driven only by this block.

## Test plan
- Reset, start, then header 3, words 0x11, 0x22, 0x44, checksum 0x77 -> writes addr 0/1/2 = 0x11/0x22/0x44 on consecutive cycles, done = 1, cpu_stall = 0.
- Same image with checksum 0x76 -> ERROR with error = 1, cpu_stall = 1; a second start with a correct image reaches DONE.
- Header 0 followed by checksum 0 -> DONE, no imem_we pulse.
- Header 2^IMEM_BITS + 1 -> ERROR the next cycle, no writes, load_ready = 0.
- load_valid toggled randomly during a 4-word load -> writes only on accepted words, addresses contiguous, and start pulses mid-load are ignored.
- reset asserted after the 2nd payload word -> outputs reset asynchronously and no third write occurs; after release, the state is IDLE and cpu_stall = 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding, default memory width and header range limit
package imem_loader_pkg;
    localparam int IMEM_BITS_DEF = 10;
    localparam int IMEM_SIZE_DEF = 1 << IMEM_BITS_DEF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        LOAD   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    // Largest payload word count that fits between base and the top of memory
    function automatic logic [32:0] range_limit(input int bits, input int base);
        return (33'd1 << bits) - 33'(base);
    endfunction
endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams a header/payload/checksum image into instruction memory
// and stalls the CPU until the image is written and verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_BITS = IMEM_BITS_DEF,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_stall,
    output logic        done,
    output logic        error
);
    localparam logic [IMEM_BITS:0] ONE = 1;

    state_t state, state_nx;
    logic [IMEM_BITS:0] cnt, n_words, cnt_inc;
    logic [31:0] csum;
    logic accept, hdr_big, last;

    assign load_ready = (state == HEADER) || (state == LOAD) || (state == CHECK);
    assign accept     = load_valid && load_ready;
    assign cnt_inc    = cnt + ONE;
    assign last       = cnt_inc == n_words;
    assign hdr_big    = {1'b0, load_data} > range_limit(IMEM_BITS, BASE_ADDR);
    assign cpu_stall  = state != DONE;
    assign done       = state == DONE;
    assign error      = state == ERROR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERROR: state_nx = start ? HEADER : state;
            HEADER: if (accept) state_nx = (load_data == 32'd0) ? CHECK : hdr_big ? ERROR : LOAD;
            LOAD:   if (accept && last) state_nx = CHECK;
            CHECK:  if (accept) state_nx = (load_data == csum) ? DONE : ERROR;
            default: state_nx = IDLE;
        endcase
    end

    // Write port is registered: a word accepted at edge t is presented during cycle t+1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            n_words    <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= accept && (state == LOAD);
            if (accept && state == HEADER) begin
                n_words <= load_data[IMEM_BITS:0];
                cnt     <= '0;
                csum    <= '0;
            end
            if (accept && state == LOAD) begin
                cnt        <= cnt_inc;
                csum       <= csum ^ load_data;
                imem_addr  <= 32'(BASE_ADDR) + 32'(cnt);
                imem_wdata <= load_data;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader with a 16-word memory
module tb_imem_loader;
    localparam int BITS = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready, imem_we, cpu_stall, done, error;
    logic [31:0] imem_addr, imem_wdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    wr_t exp_q[$];
    int wr_cycles[$];
    logic [31:0] img[$];

    imem_loader #(.IMEM_BITS(BITS), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_stall(cpu_stall),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        wr_t e;
        if (imem_we) begin
            tests++;
            wr_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    fails++;
                    $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                             imem_addr, imem_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input bit gaps, input bit pulse);
        int n = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                load_valid = 1'b0;
                start = pulse && ($urandom_range(0, 1) == 1);
                @(negedge clk);
                start = 1'b0;
            end
        end
        load_valid = 1'b1;
        load_data  = w;
        while (!load_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!load_ready) begin
            fails++;
            $display("FAIL send_timeout load_ready=%b want 1", load_ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        load_valid = 1'b0;
    endtask

    task automatic load_image(input bit gaps, input bit bad, input bit pulse);
        logic [31:0] ck = '0;
        send(32'(img.size()), gaps, pulse);
        for (int k = 0; k < img.size(); k++) begin
            exp_q.push_back('{a: 32'(k), d: img[k]});
            ck ^= img[k];
            send(img[k], gaps, pulse);
        end
        send(bad ? ck ^ 32'h1 : ck, gaps, pulse);
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({imem_we, load_ready, done, error, cpu_stall} !== 5'b00001 ||
            imem_addr !== 32'd0 || imem_wdata !== 32'd0) begin
            fails++;
            $display("FAIL reset we/rdy/done/err/stall=%b addr=%h data=%h want 00001 0 0",
                     {imem_we, load_ready, done, error, cpu_stall}, imem_addr, imem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({load_ready, done, error, cpu_stall} !== 4'b0001) begin
            fails++;
            $display("FAIL idle rdy/done/err/stall=%b want 0001", {load_ready, done, error, cpu_stall});
        end
    endtask

    task automatic test_basic();
        img = '{32'h11, 32'h22, 32'h44};
        wr_cycles.delete();
        pulse_start();
        load_image(0, 0, 0);
        tests++;
        if ({done, error, cpu_stall} !== 3'b100 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL basic done/err/stall=%b pending=%0d want 100 0",
                     {done, error, cpu_stall}, exp_q.size());
        end
        tests++;
        if (wr_cycles.size() != 3 || wr_cycles[2] - wr_cycles[0] != 2) begin
            fails++;
            $display("FAIL back_to_back writes=%0d want 3 consecutive", wr_cycles.size());
        end
    endtask

    task automatic test_bad_checksum();
        img = '{32'h11, 32'h22, 32'h44};
        pulse_start();
        load_image(0, 1, 0);
        tests++;
        if ({done, error, cpu_stall} !== 3'b011 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL bad_csum done/err/stall=%b pending=%0d want 011 0",
                     {done, error, cpu_stall}, exp_q.size());
        end
        pulse_start();
        load_image(0, 0, 0);
        tests++;
        if ({done, error, cpu_stall} !== 3'b100) begin
            fails++;
            $display("FAIL recover done/err/stall=%b want 100", {done, error, cpu_stall});
        end
    endtask

    task automatic test_zero();
        img.delete();
        pulse_start();
        load_image(0, 0, 0);
        tests++;
        if ({done, error, cpu_stall} !== 3'b100) begin
            fails++;
            $display("FAIL zero done/err/stall=%b want 100", {done, error, cpu_stall});
        end
        pulse_start();
        tests++;
        if ({done, cpu_stall, load_ready} !== 3'b011) begin
            fails++;
            $display("FAIL restart done/stall/rdy=%b want 011", {done, cpu_stall, load_ready});
        end
        send(32'd0, 0, 0);
        send(32'd0, 0, 0);
    endtask

    task automatic test_boundary();
        img.delete();
        for (int k = 0; k < (1 << BITS); k++) img.push_back($urandom);
        pulse_start();
        load_image(0, 0, 0);
        tests++;
        if ({done, error} !== 2'b10 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL full_mem done/err=%b pending=%0d want 10 0", {done, error}, exp_q.size());
        end
    endtask

    task automatic test_overrange();
        pulse_start();
        send(32'((1 << BITS) + 1), 0, 0);
        tests++;
        if ({error, done, cpu_stall, load_ready} !== 4'b1010) begin
            fails++;
            $display("FAIL overrange err/done/stall/rdy=%b want 1010",
                     {error, done, cpu_stall, load_ready});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_gaps();
        img.delete();
        for (int k = 0; k < 4; k++) img.push_back($urandom);
        pulse_start();
        load_image(1, 0, 1);
        tests++;
        if ({done, error} !== 2'b10 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL gaps done/err=%b pending=%0d want 10 0", {done, error}, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send(32'd3, 0, 0);
        exp_q.push_back('{a: 32'd0, d: 32'hA0});
        send(32'hA0, 0, 0);
        exp_q.push_back('{a: 32'd1, d: 32'hA1});
        send(32'hA1, 0, 0);
        load_valid = 1'b1;
        load_data  = 32'hA2;
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({imem_we, load_ready, done, error, cpu_stall} !== 5'b00001 ||
            imem_addr !== 32'd0 || imem_wdata !== 32'd0) begin
            fails++;
            $display("FAIL async_reset we/rdy/done/err/stall=%b addr=%h want 00001 0",
                     {imem_we, load_ready, done, error, cpu_stall}, imem_addr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({load_ready, done, error, cpu_stall} !== 4'b0001 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL post_reset rdy/done/err/stall=%b pending=%0d want 0001 0",
                     {load_ready, done, error, cpu_stall}, exp_q.size());
        end
        load_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_zero();
        test_boundary();
        test_overrange();
        test_gaps();
        test_reset_mid();
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL final_pending got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
